// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multicycle controller -- FSM states,
// RV32 base opcodes, datapath select encodings and the instruction-class
// record produced by ctrl_opclass.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;

  // ALU operand A source
  localparam logic [1:0] ALU_A_REG  = 2'd0;
  localparam logic [1:0] ALU_A_ZERO = 2'd1;
  localparam logic [1:0] ALU_A_PC   = 2'd2;

  // ALU operand B source
  localparam logic ALU_B_REG = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  // Register-file write source
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // Next-pc source
  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  // One-hot instruction class; exactly one field is set for any opcode.
  typedef struct packed {
    logic r;
    logic i;
    logic lui;
    logic auipc;
    logic br;
    logic jal;
    logic jalr;
    logic ld;
    logic st;
    logic bad;
  } opclass_t;

endpackage

// File: rtl/ctrl_opclass.sv
// ctrl_opclass: maps a 7-bit opcode to a one-hot instruction class.
// Anything outside the supported RV32 base opcodes is classed as bad.
module ctrl_opclass
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output opclass_t   cls_o
);

  // Opcode to one-hot class lookup
  always_comb begin
    cls_o = '0;
    case (opcode_i)
      OP_R:     cls_o.r     = 1'b1;
      OP_I:     cls_o.i     = 1'b1;
      OP_LUI:   cls_o.lui   = 1'b1;
      OP_AUIPC: cls_o.auipc = 1'b1;
      OP_BR:    cls_o.br    = 1'b1;
      OP_JAL:   cls_o.jal   = 1'b1;
      OP_JALR:  cls_o.jalr  = 1'b1;
      OP_LD:    cls_o.ld    = 1'b1;
      OP_ST:    cls_o.st    = 1'b1;
      default:  cls_o.bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB controller for a multicycle
// RV32 datapath. Strobes and selects are decoded from the current state,
// the opcode of the latched instruction, mem_ack and br_taken, so a memory
// ack is acted upon in the cycle it arrives. Reset forces every output to
// its idle value in the same cycle, overriding mem_ack.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- when defined, an unknown
// opcode traps into HALT and sets the sticky illegal flag; otherwise it
// retires as a NOP.
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ir,
  input  logic        mem_ack,
  input  logic        br_taken,
  output logic        pc_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel,
  output logic [1:0]  pc_src,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        illegal
);

  state_t      state_q, state_d;
  logic [31:0] instret_q, instret_d;
  opclass_t    cls_s;

  // Only the opcode field steers the controller.
  logic unused_ir_bits_s;
  assign unused_ir_bits_s = ^ir[31:7];

  ctrl_opclass u_opclass (
    .opcode_i (ir[6:0]),
    .cls_o    (cls_s)
  );

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Next-state, retire counter and output strobe/select decode
  always_comb begin
    state_d   = state_q;
    instret_d = instret_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    rf_we     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_sel  = 1'b0;
    alu_a_sel = ALU_A_REG;
    alu_b_sel = ALU_B_REG;
    wb_sel    = WB_ALU;
    pc_src    = PC_PLUS4;
    if (rst) begin
      // Outputs stay idle; the register block performs the reset itself.
      state_d = ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          mem_req  = 1'b1;
          addr_sel = 1'b0;
          if (mem_ack) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            pc_src  = PC_PLUS4;
            state_d = ST_DECODE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (cls_s.bad) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d   = ST_HALT;
            illegal_d = 1'b1;
`else
            // Unknown opcode retires as a NOP.
            state_d   = ST_FETCH;
            instret_d = instret_q + 32'd1;
`endif
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cls_s.br) begin
            alu_a_sel = ALU_A_REG;
            alu_b_sel = ALU_B_REG;
            pc_we     = br_taken;
            pc_src    = PC_BRANCH;
            state_d   = ST_FETCH;
            instret_d = instret_q + 32'd1;
          end else if (cls_s.jal || cls_s.jalr) begin
            rf_we     = 1'b1;
            wb_sel    = WB_PC4;
            pc_we     = 1'b1;
            pc_src    = cls_s.jalr ? PC_JALR : PC_BRANCH;
            state_d   = ST_FETCH;
            instret_d = instret_q + 32'd1;
          end else if (cls_s.ld || cls_s.st) begin
            alu_b_sel = ALU_B_IMM;
            state_d   = ST_MEM;
          end else if (cls_s.r || cls_s.i || cls_s.lui || cls_s.auipc) begin
            if (cls_s.lui) begin
              alu_a_sel = ALU_A_ZERO;
            end else if (cls_s.auipc) begin
              alu_a_sel = ALU_A_PC;
            end else begin
              alu_a_sel = ALU_A_REG;
            end
            alu_b_sel = cls_s.r ? ALU_B_REG : ALU_B_IMM;
            state_d   = ST_WB;
          end else begin
            // Bad opcodes never reach EXEC; retire defensively.
            state_d   = ST_FETCH;
            instret_d = instret_q + 32'd1;
          end
        end
        ST_MEM: begin
          // Request, address source and write enable are held steady
          // for the whole wait.
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = cls_s.st;
          if (mem_ack) begin
            if (cls_s.ld) begin
              state_d = ST_WB;
            end else begin
              state_d   = ST_FETCH;
              instret_d = instret_q + 32'd1;
            end
          end else begin
            state_d = ST_MEM;
          end
        end
        ST_WB: begin
          rf_we     = 1'b1;
          wb_sel    = cls_s.ld ? WB_MEM : WB_ALU;
          state_d   = ST_FETCH;
          instret_d = instret_q + 32'd1;
        end
        ST_HALT: begin
          // Parked with all strobes low until reset.
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // State, retire counter and sticky flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      instret_q <= 32'd0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  assign state   = rst ? ST_FETCH : state_q;
  assign instret = rst ? 32'd0 : instret_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal = rst ? 1'b0 : illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule
